alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
- Sequences the shared ALU/shifter/divider/HiLo datapath.
- Accepts one function-code request per cycle over a valid/ready handshake. Drives the registered op select to all units. Runs the multi-cycle DIVU sequence and pulses the HiLo write.
- Replaces ad-hoc per-unit cycle counting with one owner of datapath timing. Reports completion and illegal codes back to the issuing stage.

Parameters:
- FUNCT_W, 6: width of function code and op select.
- DIV_CYCLES, 32: cycles the divider iterates before HiLo writeback; legal range 1..127.
- HILO_WB_CODE, 6'b111111: op select value that opens the HiLo registers.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_funct  input  FUNCT_W  requested function code.
- req_ready  output  1  sequencer can accept this cycle.
- abort  input  1  cancel an in-flight DIVU.
- op_sel  output  FUNCT_W  registered op select to ALU, SHT, DIV and MUX.
- op_valid  output  1  op_sel is meaningful this cycle.
- div_start  output  1  one-cycle pulse to initialise the divider.
- div_busy  output  1  DIVU iteration or writeback in progress.
- hilo_we  output  1  HiLo write enable.
- done_valid  output  1  one-cycle completion pulse.
- done_funct  output  FUNCT_W  code of the completing op.
- done_err  output  1  qualifies done_valid: illegal code or aborted divide.

Behaviour:
- Clock is clk. Reset is asynchronous and active-low on rst_n.
- Reset values:
  - all outputs 0, except req_ready = 1 once rst_n is high;
  - state IDLE;
  - counter 0.
- Legal codes:
  - single-cycle: AND 36, OR 37, ADD 32, SUB 34, SLT 42, SLL 0, MFHI 16, MFLO 18;
  - multi-cycle: DIVU 27.
  - Any other code is illegal.
- Accept condition: req_valid && req_ready at a rising edge.
- States: IDLE, DIV_RUN, DIV_WB.
- IDLE:
  - req_ready = 1.
  - Single-cycle op accepted at edge N: in cycle N+1, op_sel = funct, op_valid = 1, done_valid = 1, done_funct = funct, done_err = 0. Back-to-back accepts give throughput of 1 op/cycle.
  - Illegal code accepted: in cycle N+1, op_valid = 0, op_sel holds its previous value, done_valid = 1, done_err = 1.
  - DIVU accepted at edge N: go to DIV_RUN. Counter loads 1.
  - No accept: op_valid = 0, done_valid = 0, op_sel holds.
- DIV_RUN:
  - op_sel = DIVU, op_valid = 1, div_busy = 1, req_ready = 0.
  - div_start = 1 only in the first DIV_RUN cycle (N+1).
  - Counter increments each cycle. When counter == DIV_CYCLES at an edge, go to DIV_WB.
  - DIV_RUN therefore occupies exactly DIV_CYCLES cycles, N+1 .. N+DIV_CYCLES.
- DIV_WB (cycle N+DIV_CYCLES+1):
  - op_sel = HILO_WB_CODE, op_valid = 1, hilo_we = 1, div_busy = 1.
  - done_valid = 1, done_funct = DIVU, done_err = 0.
  - req_ready = 1. A request accepted at the end of this cycle issues in the next cycle, so MFHI/MFLO observe the new HiLo value with no bubble.
  - Next state is IDLE. If a single-cycle op was accepted, its behaviour applies as from IDLE. If DIVU was accepted, go directly to DIV_RUN.
- abort:
  - Sampled only in DIV_RUN.
  - Abort at edge M: in cycle M+1, state is IDLE, hilo_we = 0, done_valid = 1, done_funct = DIVU, done_err = 1, op_valid = 0, div_busy = 0.
  - abort in IDLE or DIV_WB is ignored.
- Counter:
  - width = bits needed for DIV_CYCLES;
  - cleared in IDLE;
  - never wraps because it is reloaded on every DIVU accept.
- Reset mid-division: immediate return to reset values. No hilo_we or done pulse is generated.
- req_funct is don't-care when req_valid = 0. Inputs are not sampled while req_ready = 0.

Test Plan:
- Reset, then ADD(32), SUB(34), SLT(42) on consecutive cycles → op_sel = 32, 34, 42 in cycles 1..3 after accept; done_valid high on 3 consecutive cycles; done_err = 0.
- DIVU accepted at edge 0 (DIV_CYCLES = 32) → div_start only in cycle 1; op_sel = 27 and req_ready = 0 for cycles 1..32; cycle 33 has op_sel = 63, hilo_we = 1, done_valid = 1; req_valid held with MFHI issues op_sel = 16 in cycle 34.
- Illegal code 5 → done_valid = 1, done_err = 1, op_valid = 0, op_sel unchanged.
- DIVU then abort at cycle 10 → cycle 11 is IDLE with done_err = 1, no hilo_we at any time, next ADD accepted at cycle 11.
- rst_n low at cycle 20 of a DIVU → all outputs 0 asynchronously; after release, a new DIVU runs the full 32 cycles with a single div_start.
- Back-to-back DIVU accepted in DIV_WB → hilo_we pulses exactly once per divide; the second DIV_RUN starts the cycle after DIV_WB.

Source files
------------

// File: rtl/alu_op_sequencer_if.sv
// Request/issue bundle between the issuing stage and the datapath sequencer; master issues, slave sequences.
// Purely wiring: no latency; backpressure carried by req_ready.
interface alu_op_sequencer_if #(
    parameter int FUNCT_W = 6
);
    logic               req_valid;
    logic [FUNCT_W-1:0] req_funct;
    logic               req_ready;
    logic               abort;
    logic [FUNCT_W-1:0] op_sel;
    logic               op_valid;
    logic               div_start;
    logic               div_busy;
    logic               hilo_we;
    logic               done_valid;
    logic [FUNCT_W-1:0] done_funct;
    logic               done_err;

    modport master (
        output req_valid, req_funct, abort,
        input  req_ready, op_sel, op_valid, div_start, div_busy, hilo_we,
               done_valid, done_funct, done_err
    );

    modport slave (
        input  req_valid, req_funct, abort,
        output req_ready, op_sel, op_valid, div_start, div_busy, hilo_we,
               done_valid, done_funct, done_err
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Owns ALU/SHT/DIV/HiLo timing: single-cycle ops issue 1 cycle after accept, DIVU runs DIV_CYCLES then a HiLo writeback.
// Backpressure: req_ready drops for the whole divider run; it is high in IDLE and in the writeback cycle.
module alu_op_sequencer #(
    parameter int                 FUNCT_W      = 6,
    parameter int                 DIV_CYCLES   = 32,
    parameter logic [FUNCT_W-1:0] HILO_WB_CODE = {FUNCT_W{1'b1}}
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_op_sequencer_if.slave  bus
);
    localparam int CNT_W = $clog2(DIV_CYCLES + 1);

    localparam logic [FUNCT_W-1:0] F_SLL  = FUNCT_W'(0);
    localparam logic [FUNCT_W-1:0] F_MFHI = FUNCT_W'(16);
    localparam logic [FUNCT_W-1:0] F_MFLO = FUNCT_W'(18);
    localparam logic [FUNCT_W-1:0] F_DIVU = FUNCT_W'(27);
    localparam logic [FUNCT_W-1:0] F_ADD  = FUNCT_W'(32);
    localparam logic [FUNCT_W-1:0] F_SUB  = FUNCT_W'(34);
    localparam logic [FUNCT_W-1:0] F_AND  = FUNCT_W'(36);
    localparam logic [FUNCT_W-1:0] F_OR   = FUNCT_W'(37);
    localparam logic [FUNCT_W-1:0] F_SLT  = FUNCT_W'(42);

    typedef enum logic [1:0] {IDLE, DIV_RUN, DIV_WB} state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [FUNCT_W-1:0] op_sel_q;
    logic               op_valid_q;
    logic               div_start_q;
    logic               div_busy_q;
    logic               hilo_we_q;
    logic               done_valid_q;
    logic [FUNCT_W-1:0] done_funct_q;
    logic               done_err_q;

    logic accept;
    logic is_single;
    logic is_divu;

    // Gated by rst_n so the issuing stage sees no ready while held in reset.
    assign bus.req_ready = rst_n && (state_q != DIV_RUN);
    assign accept        = bus.req_valid && bus.req_ready;
    assign is_divu       = (bus.req_funct == F_DIVU);

    always_comb begin
        is_single = 1'b0;
        case (bus.req_funct)
            F_AND, F_OR, F_ADD, F_SUB, F_SLT, F_SLL, F_MFHI, F_MFLO: is_single = 1'b1;
            default: is_single = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            op_sel_q     <= '0;
            op_valid_q   <= 1'b0;
            div_start_q  <= 1'b0;
            div_busy_q   <= 1'b0;
            hilo_we_q    <= 1'b0;
            done_valid_q <= 1'b0;
            done_funct_q <= '0;
            done_err_q   <= 1'b0;
        end else begin
            div_start_q  <= 1'b0;
            hilo_we_q    <= 1'b0;
            done_valid_q <= 1'b0;
            done_err_q   <= 1'b0;
            case (state_q)
                DIV_RUN: begin
                    if (bus.abort) begin
                        state_q      <= IDLE;
                        cnt_q        <= '0;
                        op_valid_q   <= 1'b0;
                        div_busy_q   <= 1'b0;
                        done_valid_q <= 1'b1;
                        done_funct_q <= F_DIVU;
                        done_err_q   <= 1'b1;
                    end else if (cnt_q == CNT_W'(DIV_CYCLES)) begin
                        state_q      <= DIV_WB;
                        cnt_q        <= '0;
                        op_sel_q     <= HILO_WB_CODE;
                        op_valid_q   <= 1'b1;
                        div_busy_q   <= 1'b1;
                        hilo_we_q    <= 1'b1;
                        done_valid_q <= 1'b1;
                        done_funct_q <= F_DIVU;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                // IDLE and DIV_WB both accept; the writeback cycle behaves like IDLE for the next request.
                default: begin
                    state_q    <= IDLE;
                    cnt_q      <= '0;
                    op_valid_q <= 1'b0;
                    div_busy_q <= 1'b0;
                    if (accept) begin
                        if (is_divu) begin
                            state_q     <= DIV_RUN;
                            cnt_q       <= CNT_W'(1);
                            op_sel_q    <= F_DIVU;
                            op_valid_q  <= 1'b1;
                            div_busy_q  <= 1'b1;
                            div_start_q <= 1'b1;
                        end else if (is_single) begin
                            op_sel_q     <= bus.req_funct;
                            op_valid_q   <= 1'b1;
                            done_valid_q <= 1'b1;
                            done_funct_q <= bus.req_funct;
                        end else begin
                            done_valid_q <= 1'b1;
                            done_funct_q <= bus.req_funct;
                            done_err_q   <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.op_sel     = op_sel_q;
    assign bus.op_valid   = op_valid_q;
    assign bus.div_start  = div_start_q;
    assign bus.div_busy   = div_busy_q;
    assign bus.hilo_we    = hilo_we_q;
    assign bus.done_valid = done_valid_q;
    assign bus.done_funct = done_funct_q;
    assign bus.done_err   = done_err_q;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: vector table for single-cycle/illegal codes, hand sequences for divide corners.
module tb_alu_op_sequencer;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_fail;
    int   we_cnt;

    alu_op_sequencer_if #(.FUNCT_W(6)) bus ();

    alu_op_sequencer #(
        .FUNCT_W     (6),
        .DIV_CYCLES  (32),
        .HILO_WB_CODE(6'b111111)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       vld;
        logic [5:0] funct;
        logic       ov;
        logic [5:0] sel;
        logic       dv;
        logic       de;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (bus.hilo_we === 1'b1) we_cnt++;
    endtask

    task automatic chk_idle_quiet(input string tag);
        chk({tag, ".div_busy"},  32'(bus.div_busy),  32'd0);
        chk({tag, ".div_start"}, 32'(bus.div_start), 32'd0);
        chk({tag, ".hilo_we"},   32'(bus.hilo_we),   32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".op_sel"},     32'(bus.op_sel),     32'd0);
        chk({tag, ".op_valid"},   32'(bus.op_valid),   32'd0);
        chk({tag, ".done_valid"}, 32'(bus.done_valid), 32'd0);
        chk({tag, ".done_funct"}, 32'(bus.done_funct), 32'd0);
        chk({tag, ".done_err"},   32'(bus.done_err),   32'd0);
        chk({tag, ".req_ready"},  32'(bus.req_ready),  32'd0);
        chk_idle_quiet(tag);
    endtask

    initial begin
        int starts;
        int runlen;
        n_cmp  = 0;
        n_fail = 0;
        we_cnt = 0;

        vecs[0]  = '{1'b1, 6'd32, 1'b1, 6'd32, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, 6'd34, 1'b1, 6'd34, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 6'd42, 1'b1, 6'd42, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 6'd36, 1'b1, 6'd36, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 6'd37, 1'b1, 6'd37, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 6'd0,  1'b1, 6'd0,  1'b1, 1'b0};
        vecs[6]  = '{1'b1, 6'd16, 1'b1, 6'd16, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 6'd18, 1'b1, 6'd18, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 6'd5,  1'b0, 6'd18, 1'b1, 1'b1};
        vecs[9]  = '{1'b0, 6'd32, 1'b0, 6'd18, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 6'd63, 1'b0, 6'd18, 1'b1, 1'b1};
        vecs[11] = '{1'b1, 6'd32, 1'b1, 6'd32, 1'b1, 1'b0};

        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_funct = 6'd0;
        bus.abort     = 1'b0;
        #2;
        chk_all_zero("reset");
        #1 rst_n = 1'b1;
        #1;
        chk("reset.req_ready_after_release", 32'(bus.req_ready), 32'd1);
        step();

        // Table: each record is issued for one edge, outputs checked in the following cycle.
        for (int i = 0; i < 12; i++) begin
            bus.req_valid = vecs[i].vld;
            bus.req_funct = vecs[i].funct;
            step();
            chk($sformatf("vec%0d.op_valid", i),   32'(bus.op_valid),   32'(vecs[i].ov));
            chk($sformatf("vec%0d.op_sel", i),     32'(bus.op_sel),     32'(vecs[i].sel));
            chk($sformatf("vec%0d.done_valid", i), 32'(bus.done_valid), 32'(vecs[i].dv));
            if (vecs[i].dv) begin
                chk($sformatf("vec%0d.done_err", i),   32'(bus.done_err),   32'(vecs[i].de));
                chk($sformatf("vec%0d.done_funct", i), 32'(bus.done_funct), 32'(vecs[i].funct));
            end
            chk($sformatf("vec%0d.req_ready", i), 32'(bus.req_ready), 32'd1);
            chk_idle_quiet($sformatf("vec%0d", i));
        end
        bus.req_valid = 1'b0;
        step();

        // Full DIVU with MFHI held valid through the run.
        we_cnt = 0;
        bus.req_valid = 1'b1;
        bus.req_funct = 6'd27;
        step();
        bus.req_funct = 6'd16;
        for (int k = 1; k <= 32; k++) begin
            chk($sformatf("div.c%0d.op_sel", k),    32'(bus.op_sel),    32'd27);
            chk($sformatf("div.c%0d.op_valid", k),  32'(bus.op_valid),  32'd1);
            chk($sformatf("div.c%0d.req_ready", k), 32'(bus.req_ready), 32'd0);
            chk($sformatf("div.c%0d.div_busy", k),  32'(bus.div_busy),  32'd1);
            chk($sformatf("div.c%0d.div_start", k), 32'(bus.div_start), (k == 1) ? 32'd1 : 32'd0);
            chk($sformatf("div.c%0d.done_valid", k), 32'(bus.done_valid), 32'd0);
            step();
        end
        chk("div.wb.op_sel",     32'(bus.op_sel),     32'd63);
        chk("div.wb.hilo_we",    32'(bus.hilo_we),    32'd1);
        chk("div.wb.done_valid", 32'(bus.done_valid), 32'd1);
        chk("div.wb.done_funct", 32'(bus.done_funct), 32'd27);
        chk("div.wb.done_err",   32'(bus.done_err),   32'd0);
        chk("div.wb.div_busy",   32'(bus.div_busy),   32'd1);
        chk("div.wb.req_ready",  32'(bus.req_ready),  32'd1);
        step();
        bus.req_valid = 1'b0;
        chk("div.mfhi.op_sel",     32'(bus.op_sel),     32'd16);
        chk("div.mfhi.op_valid",   32'(bus.op_valid),   32'd1);
        chk("div.mfhi.done_funct", 32'(bus.done_funct), 32'd16);
        chk("div.mfhi.hilo_we",    32'(bus.hilo_we),    32'd0);
        chk("div.mfhi.div_busy",   32'(bus.div_busy),   32'd0);
        chk("div.we_count",        32'(we_cnt),         32'd1);
        step();

        // DIVU aborted at the edge ending cycle 10; ADD waits then issues.
        we_cnt = 0;
        bus.req_valid = 1'b1;
        bus.req_funct = 6'd27;
        step();
        bus.req_funct = 6'd32;
        for (int k = 1; k < 10; k++) step();
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        chk("abort.done_valid", 32'(bus.done_valid), 32'd1);
        chk("abort.done_err",   32'(bus.done_err),   32'd1);
        chk("abort.done_funct", 32'(bus.done_funct), 32'd27);
        chk("abort.op_valid",   32'(bus.op_valid),   32'd0);
        chk("abort.div_busy",   32'(bus.div_busy),   32'd0);
        chk("abort.req_ready",  32'(bus.req_ready),  32'd1);
        step();
        bus.req_valid = 1'b0;
        chk("abort.add.op_sel",   32'(bus.op_sel),   32'd32);
        chk("abort.add.op_valid", 32'(bus.op_valid), 32'd1);
        chk("abort.add.done_err", 32'(bus.done_err), 32'd0);
        for (int k = 0; k < 40; k++) step();
        chk("abort.we_count", 32'(we_cnt), 32'd0);

        // Reset asserted mid-divide (cycle 20), then a clean DIVU.
        we_cnt = 0;
        bus.req_valid = 1'b1;
        bus.req_funct = 6'd27;
        step();
        bus.req_valid = 1'b0;
        for (int k = 1; k < 20; k++) step();
        #3 rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        @(posedge clk);
        #2 rst_n = 1'b1;
        step();
        chk("midreset.we_count", 32'(we_cnt), 32'd0);
        chk("midreset.done_valid", 32'(bus.done_valid), 32'd0);
        bus.req_valid = 1'b1;
        bus.req_funct = 6'd27;
        step();
        bus.req_valid = 1'b0;
        starts = 0;
        runlen = 0;
        for (int k = 0; k < 40 && bus.hilo_we !== 1'b1; k++) begin
            if (bus.div_start === 1'b1) starts++;
            if (bus.op_valid === 1'b1 && bus.op_sel === 6'd27) runlen++;
            step();
        end
        chk("postreset.wb_reached", 32'(bus.hilo_we), 32'd1);
        chk("postreset.starts",     32'(starts),      32'd1);
        chk("postreset.run_len",    32'(runlen),      32'd32);
        chk("postreset.we_count",   32'(we_cnt),      32'd1);
        step();

        // Back-to-back DIVU: second one accepted in the writeback cycle.
        we_cnt = 0;
        bus.req_valid = 1'b1;
        bus.req_funct = 6'd27;
        step();
        for (int k = 1; k < 33; k++) step();
        chk("b2b.wb1.hilo_we", 32'(bus.hilo_we), 32'd1);
        step();
        bus.req_valid = 1'b0;
        chk("b2b.run2.op_sel",    32'(bus.op_sel),    32'd27);
        chk("b2b.run2.div_start", 32'(bus.div_start), 32'd1);
        chk("b2b.run2.req_ready", 32'(bus.req_ready), 32'd0);
        chk("b2b.run2.hilo_we",   32'(bus.hilo_we),   32'd0);
        for (int k = 0; k < 31; k++) step();
        chk("b2b.mid.we_count", 32'(we_cnt), 32'd1);
        step();
        chk("b2b.wb2.hilo_we",    32'(bus.hilo_we),    32'd1);
        chk("b2b.wb2.done_funct", 32'(bus.done_funct), 32'd27);
        step();
        chk("b2b.idle.div_busy", 32'(bus.div_busy), 32'd0);
        chk("b2b.we_count",      32'(we_cnt),       32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule
